// File: rtl/add_seq_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add_seq_arbiter: two-requester round-robin front-end to a 64-bit adder    |
// | computed as NSLICE sequential SLICE_W-bit passes with a registered carry. |
// | Optional feature macro: ADD_SEQ_SUB_EN (subtract via ~B and carry-in 1).  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module add_seq_arbiter #(
  parameter int SLICE_W = 16,
  parameter int NSLICE  = 64 / SLICE_W
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req0_cin,
  input  logic        req0_sub,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic        req1_cin,
  input  logic        req1_sub,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_sum,
  output logic        resp_cout,
  output logic        busy
);

  localparam int               CNT_W      = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic               last_grant;
  logic [CNT_W-1:0]   slice_cnt;
  logic               carry_reg;
  logic [63:0]        a_reg;
  logic [63:0]        b_reg;
  logic [63:0]        sum_work;
  logic               id_reg;

  logic               grant;
  logic               accept;
  logic               last_pass;

  logic [63:0]        sel_a;
  logic [63:0]        sel_b;
  logic               sel_cin;
  logic [63:0]        acc_b;
  logic               acc_carry;

  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W:0]   slice_sum;
  logic [63:0]        sum_next;

  // ---------------------------------------------------------------------------
  // Arbitration: a tie goes to whichever requester was not served last.
  // ---------------------------------------------------------------------------
  assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_a   = grant ? req1_a   : req0_a;
  assign sel_b   = grant ? req1_b   : req0_b;
  assign sel_cin = grant ? req1_cin : req0_cin;

`ifdef ADD_SEQ_SUB_EN
  logic sel_sub;

  // Subtraction is A + ~B + 1; the caller's carry-in is overridden.
  assign sel_sub   = grant ? req1_sub : req0_sub;
  assign acc_b     = sel_sub ? ~sel_b : sel_b;
  assign acc_carry = sel_sub ? 1'b1   : sel_cin;
`else
  logic unused_sub;

  assign unused_sub = req0_sub ^ req1_sub;
  assign acc_b      = sel_b;
  assign acc_carry  = sel_cin;
`endif

  // ---------------------------------------------------------------------------
  // Slice datapath: one SLICE_W-bit add per CALC cycle, LSB slice first.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (slice_cnt == CNT_W'(k)) begin
        a_slice = a_reg[k*SLICE_W +: SLICE_W];
        b_slice = b_reg[k*SLICE_W +: SLICE_W];
      end
    end
  end

  assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE_W{1'b0}}, carry_reg};

  always_comb begin
    sum_next = sum_work;
    for (int k = 0; k < NSLICE; k++) begin
      if (slice_cnt == CNT_W'(k)) begin
        sum_next[k*SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
      end
    end
  end

  assign last_pass = (slice_cnt == LAST_SLICE);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_pass) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Operand capture, slice sequencing and result registers. The visible
  // result is loaded only on the final pass so it never shows partial sums.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      slice_cnt  <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_work   <= '0;
      id_reg     <= 1'b0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      resp_id    <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        a_reg      <= sel_a;
        b_reg      <= acc_b;
        carry_reg  <= acc_carry;
        id_reg     <= grant;
        last_grant <= grant;
        slice_cnt  <= '0;
      end else if (state == CALC) begin
        sum_work  <= sum_next;
        carry_reg <= slice_sum[SLICE_W];
        slice_cnt <= slice_cnt + 1'b1;
        if (last_pass) begin
          resp_sum  <= sum_next;
          resp_cout <= slice_sum[SLICE_W];
          resp_id   <= id_reg;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_seq_arbiter.sv
`default_nettype none
// Testbench for add_seq_arbiter: table-driven add vectors plus directed
// round-robin, backpressure, mid-operation reset and random golden-model runs.
module tb_add_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_cin = 1'b0, req0_sub = 1'b0, req1_cin = 1'b0, req1_sub = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_id;
  logic [63:0] resp_sum;
  logic        resp_cout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  add_seq_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_sub   (req1_sub),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one operation, check accept, 4-edge latency, result and return to IDLE.
  task automatic run_op(input int port, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input logic [63:0] es,
                        input logic ec, input string name);
    int   n;
    logic rdy;
    @(posedge clk); #1;
    if (port == 0) begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_valid = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      rdy = (port == 0) ? req0_ready : req1_ready;
      n++;
    end while (!rdy && n < 20);
    check($sformatf("%s accept", name), 65'(rdy), 65'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    check($sformatf("%s latency", name), 65'(n), 65'd5);
    check($sformatf("%s sum", name), {1'b0, resp_sum}, {1'b0, es});
    check($sformatf("%s cout", name), 65'(resp_cout), 65'(ec));
    check($sformatf("%s id", name), 65'(resp_id), 65'(port[0]));
    wait_idle();
    check($sformatf("%s idle", name), 65'({resp_valid, busy}), 65'd0);
  endtask

  initial begin
    int          n;
    int          nacc;
    int          nresp;
    int          last_cyc;
    logic        seen;
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] gold;

    vecs[0] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
    vecs[1] = '{1, 64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0};
    vecs[2] = '{0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0};
    vecs[3] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h1, 1'b1};
    vecs[4] = '{0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                64'h0001_0000_0001_0000, 1'b0};
    vecs[5] = '{1, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
    vecs[6] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset flags", 65'({resp_valid, busy, resp_cout, resp_id, req0_ready, req1_ready}), 65'd0);
    check("reset sum", {1'b0, resp_sum}, 65'd0);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
             vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));
    end

`ifdef ADD_SEQ_SUB_EN
    run_op(0, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "sub 5-7");
    run_op(1, 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, "sub 7-5");
`else
    run_op(0, 64'd5, 64'd7, 1'b0, 1'b1, 64'd12, 1'b0, "sub ignored");
`endif

    // Round-robin ties: both valid held, grants 0,1,0,1 six cycles apart
    do_reset();
    req0_a = 64'd1;  req0_b = 64'd2;  req0_cin = 1'b0; req0_sub = 1'b0;
    req1_a = 64'd10; req1_b = 64'd20; req1_cin = 1'b0; req1_sub = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    nacc = 0; nresp = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 60 && nresp < 4; cyc++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) check("rr single ready", 65'd2, 65'd1);
      if (req0_ready || req1_ready) begin
        check($sformatf("rr grant%0d", nacc), 65'(req1_ready), 65'(nacc % 2));
        if (nacc > 0) check($sformatf("rr gap%0d", nacc), 65'(cyc - last_cyc), 65'd6);
        last_cyc = cyc;
        nacc++;
        if (nacc == 4) begin
          @(posedge clk); #1;
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      if (resp_valid) begin
        check($sformatf("rr id%0d", nresp), 65'(resp_id), 65'(nresp % 2));
        check($sformatf("rr sum%0d", nresp), {1'b0, resp_sum}, (nresp % 2 == 0) ? 65'd3 : 65'd30);
        nresp++;
      end
    end
    check("rr responses", 65'(nresp), 65'd4);
    wait_idle();

    // Backpressure: DONE holds with stable outputs while resp_ready is low
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req0_a = 64'd3; req0_b = 64'd4; req0_cin = 1'b0; req0_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    check("bp reached done", 65'(resp_valid), 65'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp flags", 65'({resp_valid, busy, req0_ready, req1_ready, resp_cout, resp_id}),
            65'(6'b110000));
      check("bp sum", {1'b0, resp_sum}, 65'd7);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    wait_idle();
    check("bp release idle", 65'({resp_valid, busy}), 65'd0);

    // Reset during the second CALC cycle
    @(posedge clk); #1;
    req0_a = 64'd1; req0_b = 64'd1; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 64'd8; req1_b = 64'd8; req1_cin = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid-reset flags", 65'({resp_valid, busy, resp_cout, resp_id}), 65'd0);
    check("mid-reset sum", {1'b0, resp_sum}, 65'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    check("mid-reset no resp", 65'(seen), 65'd0);
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check("mid-reset tie grant", 65'({req0_ready, req1_ready}), 65'(2'b10));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    check("mid-reset tie result", 65'({resp_valid, resp_id, resp_cout}), 65'(3'b100));
    check("mid-reset tie sum", {1'b0, resp_sum}, 65'd2);
    wait_idle();

    // Random regression against the 65-bit golden sum
    for (int i = 0; i < 500; i++) begin
      ra   = {$urandom(), $urandom()};
      rb   = {$urandom(), $urandom()};
      rc   = 1'($urandom_range(0, 1));
      gold = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
      run_op(i % 2, ra, rb, rc, 1'b0, gold[63:0], gold[64], $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
